ram_arbiter: RTL and testbench
==============================

RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 The block SHALL expose parameter BURST_LEN, default 4, meaning the number of 32-bit beats in one burst (power of two, 2..16).
REQ-002 The block SHALL expose the ports below, one per line; port-indexed signals are arrays indexed [1:0] (port 0, port 1).
  clk  in  1  the single clock; all state on rising edge.
  rst_i  in  1  reset, asynchronous and active-high.
  p_req_i  in  2  per-port request, held high until the last gnt of the transaction.
  p_burst_i  in  2  per-port burst qualifier, sampled with the first grant.
  p_we_i  in  2x4  per-port byte-write strobe: 1111, 0011 or 0001; 0000 means read.
  p_addr_i  in  2x32  per-port byte address.
  p_wdata_i  in  2x32  per-port write data for the current beat.
  p_gnt_o  out  2  per-port one-cycle beat-accepted pulse.
  p_rvalid_o  out  2  per-port read data valid, one cycle after a read grant.
  p_rdata_o  out  32  read data, shared by both ports, qualified by p_rvalid_o.
  ram_en_o  out  1  RAM enable.
  ram_we_o  out  4  RAM write strobe.
  ram_addr_o  out  32  RAM byte address.
  ram_din_o  out  32  RAM write data.
  ram_dout_i  in  32  RAM read data, combinational from ram_addr_o.

Function
REQ-003 The FSM SHALL have exactly two states: IDLE and BURST.
REQ-004 In IDLE, when any p_req_i is high, the arbiter SHALL pick one port, drive ram_en_o=1 with that port's addr, we and wdata, and pulse its p_gnt_o in the same cycle.
REQ-005 Arbitration SHALL be round-robin: a last-winner pointer (reset 1) gives priority to the other port when both request, and it updates on every first beat granted.
REQ-006 With a single requester, that requester SHALL win regardless of the pointer.
REQ-007 A single-beat transaction SHALL occupy one cycle; the arbiter SHALL remain in IDLE, so back-to-back grants occur on consecutive cycles.
REQ-008 For read beats, p_rdata_o SHALL register ram_dout_i and the owning p_rvalid_o SHALL pulse exactly one cycle after the grant; for write beats, p_rvalid_o SHALL stay low.
REQ-009 When the granted p_burst_i=1, the arbiter SHALL latch the owner, base address (bits [1:0] forced to 00), we and beat counter=1, then enter BURST.
REQ-010 In BURST, each cycle the arbiter SHALL issue a beat at base+4*count for the owner only, pulse its p_gnt_o and take p_wdata_i live; the requester SHALL present the next word after each gnt.
REQ-011 The beat counter SHALL increment per beat; after beat BURST_LEN-1 the counter SHALL wrap to 0 and the FSM SHALL return to IDLE.
REQ-012 Burst address arithmetic SHALL be modulo 2^32 (0xFFFFFFFC + 4 = 0x00000000), with no block-boundary wrap.
REQ-013 If the owner drops p_req_i in BURST, the arbiter SHALL issue no beat that cycle, abort, and return to IDLE; rvalid for already-issued beats SHALL still be delivered.
REQ-014 Requests from the non-owner during BURST SHALL be stalled (no gnt) until the FSM returns to IDLE.
REQ-015 When no beat is issued, ram_en_o and ram_we_o SHALL be 0; ram_addr_o and ram_din_o are don't-care.

Reset
REQ-016 On rst_i high, asynchronously: state=IDLE, counter=0, pointer=1, p_gnt_o=0, p_rvalid_o=0, p_rdata_o=0, ram_en_o=0, ram_we_o=0.
REQ-017 Reset mid-burst SHALL discard the burst; no rvalid SHALL follow the reset release for pre-reset beats.

Configuration
REQ-018 With macro RAM_ARB_BURST_EN defined, burst logic (REQ-009..REQ-014) SHALL be compiled in.
REQ-019 Without RAM_ARB_BURST_EN, p_burst_i SHALL be ignored, the BURST state and counter SHALL not exist, and every transaction SHALL be single-beat.

Structure
REQ-020 Package ram_arb_pkg SHALL hold the state enum (IDLE, BURST), N_PORTS=2 and the strobe constants WE_WORD=1111, WE_HALF=0011, WE_BYTE=0001, WE_NONE=0000.
REQ-021 Sub-module rr_arb2 SHALL implement the combinational 2-way round-robin pick (req[1:0], pointer -> grant one-hot).

Verification
REQ-022 Port 0 reads 0x10 alone (RAM word 4 = 4) -> gnt0 in cycle 0, rvalid0 with rdata=4 in cycle 1.
REQ-023 Both ports request single reads at 0x0/0x4 after reset -> port 0 granted first, port 1 next cycle; rdata 0 then 1.
REQ-024 Port 1 issues a burst read at 0x22 with BURST_LEN=4 -> addresses 0x20,0x24,0x28,0x2C; rdata 8,9,10,11; port 0 stalled throughout.
REQ-025 Port 0 issues a burst write of words 0xA..0xD at 0x0 and drops req after beat 2 -> only 0x0,0x4 written; returns to IDLE.
REQ-026 rst_i asserted during beat 2 of a burst -> outputs zero immediately; no rvalid after release; next request is arbitrated from IDLE.
REQ-027 Build without RAM_ARB_BURST_EN and drive p_burst_i=1 -> single-beat only, one gnt per request.

Source files
------------

// File: rtl/ram_arbiter_pkg.sv
// Shared types, strobe encodings and helpers for the dual-port RAM arbiter.
package ram_arb_pkg;

    localparam int N_PORTS = 2;

    localparam logic [3:0] WE_WORD = 4'b1111;
    localparam logic [3:0] WE_HALF = 4'b0011;
    localparam logic [3:0] WE_BYTE = 4'b0001;
    localparam logic [3:0] WE_NONE = 4'b0000;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_e;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/ram_arbiter_if.sv
// Bundle of both requester ports and the RAM-side bus; slave = arbiter, master = environment.
interface ram_arbiter_if;
    import ram_arb_pkg::*;

    logic [N_PORTS-1:0]       p_req_i;
    logic [N_PORTS-1:0]       p_burst_i;
    logic [N_PORTS-1:0][3:0]  p_we_i;
    logic [N_PORTS-1:0][31:0] p_addr_i;
    logic [N_PORTS-1:0][31:0] p_wdata_i;
    logic [N_PORTS-1:0]       p_gnt_o;
    logic [N_PORTS-1:0]       p_rvalid_o;
    logic [31:0]              p_rdata_o;
    logic                     ram_en_o;
    logic [3:0]               ram_we_o;
    logic [31:0]              ram_addr_o;
    logic [31:0]              ram_din_o;
    logic [31:0]              ram_dout_i;

    modport slave (
        input  p_req_i, p_burst_i, p_we_i, p_addr_i, p_wdata_i, ram_dout_i,
        output p_gnt_o, p_rvalid_o, p_rdata_o, ram_en_o, ram_we_o, ram_addr_o, ram_din_o
    );

    modport master (
        output p_req_i, p_burst_i, p_we_i, p_addr_i, p_wdata_i, ram_dout_i,
        input  p_gnt_o, p_rvalid_o, p_rdata_o, ram_en_o, ram_we_o, ram_addr_o, ram_din_o
    );

endinterface

// File: rtl/ram_arbiter_rr_arb2.sv
// Combinational two-way round-robin pick; ptr_i is the index of the last winner.
module rr_arb2 (
    input  logic [1:0] req_i,
    input  logic       ptr_i,
    output logic [1:0] gnt_o
);

    // On contention the port that did not win last time goes first.
    always_comb begin
        gnt_o = 2'b00;
        case (req_i)
            2'b01:   gnt_o = 2'b01;
            2'b10:   gnt_o = 2'b10;
            2'b11:   gnt_o = ptr_i ? 2'b01 : 2'b10;
            default: gnt_o = 2'b00;
        endcase
    end

endmodule

// File: rtl/ram_arbiter.sv
// Two-port single-RAM arbiter; define RAM_ARB_BURST_EN to compile in fixed-length bursts.
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int BURST_LEN = 4
) (
    input  logic         clk,
    input  logic         rst_i,
    ram_arbiter_if.slave bus
);

    logic [1:0]  rr_gnt;
    logic        win;
    logic        first_beat;
    logic        align_first;
    logic [1:0]  gnt;
    logic [3:0]  we;
    logic [31:0] addr;
    logic [31:0] din;
    logic        ptr_q, ptr_d;
    logic [1:0]  rvalid_q, rvalid_d;
    logic [31:0] rdata_q, rdata_d;

    rr_arb2 u_rr_arb2 (
        .req_i (bus.p_req_i),
        .ptr_i (ptr_q),
        .gnt_o (rr_gnt)
    );

    assign win = rr_gnt[1];

`ifdef RAM_ARB_BURST_EN
    localparam int CW = $clog2(BURST_LEN);

    arb_state_e  state_q, state_d;
    logic        owner_q, owner_d;
    logic [31:0] base_q, base_d;
    logic [3:0]  we_q, we_d;
    logic [CW-1:0] cnt_q, cnt_d;

    assign first_beat  = (state_q == IDLE) && (rr_gnt != 2'b00);
    assign align_first = bus.p_burst_i[win];

    // Burst context and FSM state register.
    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            base_q  <= 32'h0000_0000;
            we_q    <= WE_NONE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            base_q  <= base_d;
            we_q    <= we_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: open a burst on a qualified first grant, close it on the last beat or an owner drop.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        base_d  = base_q;
        we_d    = we_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (first_beat && bus.p_burst_i[win]) begin
                    state_d = BURST;
                    owner_d = win;
                    base_d  = word_align(bus.p_addr_i[win]);
                    we_d    = bus.p_we_i[win];
                    cnt_d   = CW'(1);
                end else begin
                    state_d = IDLE;
                end
            end
            BURST: begin
                if (!bus.p_req_i[owner_q]) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CW'(BURST_LEN - 1)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end
`else
    logic unused_cfg;

    assign first_beat  = (rr_gnt != 2'b00);
    assign align_first = 1'b0;
    assign unused_cfg  = (^bus.p_burst_i) ^ (BURST_LEN > 1);
`endif

    // Beat issue: the burst owner has the RAM, otherwise the round-robin winner; reset forces silence.
    always_comb begin
        gnt  = 2'b00;
        we   = WE_NONE;
        addr = 32'h0000_0000;
        din  = 32'h0000_0000;
        if (rst_i) begin
            gnt = 2'b00;
`ifdef RAM_ARB_BURST_EN
        end else if (state_q == BURST) begin
            if (bus.p_req_i[owner_q]) begin
                gnt[owner_q] = 1'b1;
                we   = we_q;
                addr = base_q + {{(30 - CW){1'b0}}, cnt_q, 2'b00};
                din  = bus.p_wdata_i[owner_q];
            end else begin
                gnt = 2'b00;
            end
`endif
        end else if (first_beat) begin
            gnt  = rr_gnt;
            we   = bus.p_we_i[win];
            addr = align_first ? word_align(bus.p_addr_i[win]) : bus.p_addr_i[win];
            din  = bus.p_wdata_i[win];
        end else begin
            gnt = 2'b00;
        end
    end

    assign ptr_d    = first_beat ? win : ptr_q;
    assign rvalid_d = (we == WE_NONE) ? gnt : 2'b00;
    assign rdata_d  = ((gnt != 2'b00) && (we == WE_NONE)) ? bus.ram_dout_i : rdata_q;

    // Round-robin pointer and read-return registers.
    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            ptr_q    <= 1'b1;
            rvalid_q <= 2'b00;
            rdata_q  <= 32'h0000_0000;
        end else begin
            ptr_q    <= ptr_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
        end
    end

    assign bus.p_gnt_o    = gnt;
    assign bus.p_rvalid_o = rvalid_q;
    assign bus.p_rdata_o  = rdata_q;
    assign bus.ram_en_o   = (gnt != 2'b00);
    assign bus.ram_we_o   = we;
    assign bus.ram_addr_o = addr;
    assign bus.ram_din_o  = din;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a 64-word RAM model; burst scenarios need RAM_ARB_BURST_EN.
module tb_ram_arbiter;
    import ram_arb_pkg::*;

    logic        clk;
    logic        rst_i;
    logic        mem_load;
    logic [31:0] mem [0:63];
    int          tests_run;
    int          tests_failed;

    ram_arbiter_if bus ();

    ram_arbiter #(.BURST_LEN(4)) dut (
        .clk   (clk),
        .rst_i (rst_i),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign bus.ram_dout_i = mem[bus.ram_addr_o[7:2]];

    // RAM model: word i holds i after a load, byte-strobed writes otherwise.
    always @(posedge clk) begin
        if (mem_load) begin
            for (int i = 0; i < 64; i++) mem[i] <= 32'(i);
        end else if (bus.ram_en_o) begin
            for (int b = 0; b < 4; b++)
                if (bus.ram_we_o[b]) mem[bus.ram_addr_o[7:2]][8*b +: 8] <= bus.ram_din_o[8*b +: 8];
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, tests_run=%0d", tests_run);
        $fatal(1, "watchdog expired");
    end

    task automatic clear_inputs();
        bus.p_req_i   = 2'b00;
        bus.p_burst_i = 2'b00;
        bus.p_we_i    = '0;
        bus.p_addr_i  = '0;
        bus.p_wdata_i = '0;
    endtask

    task automatic load_mem();
        @(negedge clk) mem_load = 1'b1;
        @(negedge clk) mem_load = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        bus.p_req_i = 2'b11;
        bus.p_addr_i[0] = 32'h10;
        #1;
        tests_run++; if (bus.p_gnt_o !== 2'b00) begin tests_failed++; $display("FAIL reset_gnt: got %b want 00", bus.p_gnt_o); end
        tests_run++; if (bus.ram_en_o !== 1'b0) begin tests_failed++; $display("FAIL reset_en: got %b want 0", bus.ram_en_o); end
        tests_run++; if (bus.ram_we_o !== 4'b0000) begin tests_failed++; $display("FAIL reset_we: got %b want 0000", bus.ram_we_o); end
        tests_run++; if (bus.p_rvalid_o !== 2'b00) begin tests_failed++; $display("FAIL reset_rvalid: got %b want 00", bus.p_rvalid_o); end
        tests_run++; if (bus.p_rdata_o !== 32'h0) begin tests_failed++; $display("FAIL reset_rdata: got %h want 0", bus.p_rdata_o); end
        @(negedge clk);
        rst_i = 1'b0;
        clear_inputs();
    endtask

    task automatic test_rr_after_reset();
        @(negedge clk);
        bus.p_req_i = 2'b11;
        bus.p_addr_i[0] = 32'h0;
        bus.p_addr_i[1] = 32'h4;
        #1;
        tests_run++; if (bus.p_gnt_o !== 2'b01) begin tests_failed++; $display("FAIL rr_first_gnt: got %b want 01", bus.p_gnt_o); end
        tests_run++; if (bus.ram_addr_o !== 32'h0) begin tests_failed++; $display("FAIL rr_first_addr: got %h want 0", bus.ram_addr_o); end
        @(negedge clk);
        tests_run++; if (bus.p_rvalid_o !== 2'b01) begin tests_failed++; $display("FAIL rr_first_rvalid: got %b want 01", bus.p_rvalid_o); end
        tests_run++; if (bus.p_rdata_o !== 32'h0) begin tests_failed++; $display("FAIL rr_first_rdata: got %h want 0", bus.p_rdata_o); end
        bus.p_req_i = 2'b10;
        #1;
        tests_run++; if (bus.p_gnt_o !== 2'b10) begin tests_failed++; $display("FAIL rr_second_gnt: got %b want 10", bus.p_gnt_o); end
        tests_run++; if (bus.ram_addr_o !== 32'h4) begin tests_failed++; $display("FAIL rr_second_addr: got %h want 4", bus.ram_addr_o); end
        @(negedge clk);
        tests_run++; if (bus.p_rvalid_o !== 2'b10) begin tests_failed++; $display("FAIL rr_second_rvalid: got %b want 10", bus.p_rvalid_o); end
        tests_run++; if (bus.p_rdata_o !== 32'h1) begin tests_failed++; $display("FAIL rr_second_rdata: got %h want 1", bus.p_rdata_o); end
        clear_inputs();
        #1;
        tests_run++; if (bus.ram_en_o !== 1'b0) begin tests_failed++; $display("FAIL rr_idle_en: got %b want 0", bus.ram_en_o); end
    endtask

    task automatic test_back_to_back();
        logic [1:0]  exp_g;
        logic [1:0]  prev_g;
        logic [31:0] exp_d;
        prev_g = 2'b00;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (k > 0) begin
                exp_d = (prev_g == 2'b01) ? 32'h0 : 32'h1;
                tests_run++; if (bus.p_rvalid_o !== prev_g) begin tests_failed++; $display("FAIL b2b_rvalid[%0d]: got %b want %b", k, bus.p_rvalid_o, prev_g); end
                tests_run++; if (bus.p_rdata_o !== exp_d) begin tests_failed++; $display("FAIL b2b_rdata[%0d]: got %h want %h", k, bus.p_rdata_o, exp_d); end
            end
            bus.p_req_i = 2'b11;
            bus.p_addr_i[0] = 32'h0;
            bus.p_addr_i[1] = 32'h4;
            #1;
            exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
            tests_run++; if (bus.p_gnt_o !== exp_g) begin tests_failed++; $display("FAIL b2b_gnt[%0d]: got %b want %b", k, bus.p_gnt_o, exp_g); end
            prev_g = exp_g;
        end
        @(negedge clk);
        tests_run++; if (bus.p_rvalid_o !== 2'b10) begin tests_failed++; $display("FAIL b2b_last_rvalid: got %b want 10", bus.p_rvalid_o); end
        clear_inputs();
    endtask

    task automatic test_single_read();
        @(negedge clk);
        bus.p_req_i = 2'b01;
        bus.p_addr_i[0] = 32'h10;
        #1;
        tests_run++; if (bus.p_gnt_o !== 2'b01) begin tests_failed++; $display("FAIL single_gnt: got %b want 01", bus.p_gnt_o); end
        tests_run++; if (bus.ram_en_o !== 1'b1) begin tests_failed++; $display("FAIL single_en: got %b want 1", bus.ram_en_o); end
        tests_run++; if (bus.ram_addr_o !== 32'h10) begin tests_failed++; $display("FAIL single_addr: got %h want 10", bus.ram_addr_o); end
        @(negedge clk);
        tests_run++; if (bus.p_rvalid_o !== 2'b01) begin tests_failed++; $display("FAIL single_rvalid: got %b want 01", bus.p_rvalid_o); end
        tests_run++; if (bus.p_rdata_o !== 32'h4) begin tests_failed++; $display("FAIL single_rdata: got %h want 4", bus.p_rdata_o); end
        clear_inputs();
        @(negedge clk);
        tests_run++; if (bus.p_rvalid_o !== 2'b00) begin tests_failed++; $display("FAIL single_rvalid_pulse: got %b want 00", bus.p_rvalid_o); end
    endtask

    task automatic test_write_strobes();
        @(negedge clk);
        bus.p_req_i = 2'b10; bus.p_we_i[1] = WE_WORD; bus.p_addr_i[1] = 32'h8; bus.p_wdata_i[1] = 32'h1122_3344;
        #1;
        tests_run++; if (bus.ram_we_o !== 4'b1111) begin tests_failed++; $display("FAIL wr_word_we: got %b want 1111", bus.ram_we_o); end
        tests_run++; if (bus.ram_din_o !== 32'h1122_3344) begin tests_failed++; $display("FAIL wr_word_din: got %h want 11223344", bus.ram_din_o); end
        @(negedge clk);
        tests_run++; if (bus.p_rvalid_o !== 2'b00) begin tests_failed++; $display("FAIL wr_word_rvalid: got %b want 00", bus.p_rvalid_o); end
        clear_inputs();
        bus.p_req_i = 2'b01; bus.p_we_i[0] = WE_HALF; bus.p_addr_i[0] = 32'hC; bus.p_wdata_i[0] = 32'hAAAA_BBBB;
        #1;
        tests_run++; if (bus.p_gnt_o !== 2'b01) begin tests_failed++; $display("FAIL wr_half_gnt: got %b want 01", bus.p_gnt_o); end
        tests_run++; if (bus.ram_we_o !== 4'b0011) begin tests_failed++; $display("FAIL wr_half_we: got %b want 0011", bus.ram_we_o); end
        @(negedge clk);
        tests_run++; if (bus.p_rvalid_o !== 2'b00) begin tests_failed++; $display("FAIL wr_half_rvalid: got %b want 00", bus.p_rvalid_o); end
        clear_inputs();
        bus.p_req_i = 2'b10; bus.p_we_i[1] = WE_BYTE; bus.p_addr_i[1] = 32'h8; bus.p_wdata_i[1] = 32'h0000_00EE;
        #1;
        tests_run++; if (bus.ram_we_o !== 4'b0001) begin tests_failed++; $display("FAIL wr_byte_we: got %b want 0001", bus.ram_we_o); end
        @(negedge clk);
        clear_inputs();
        bus.p_req_i = 2'b01; bus.p_addr_i[0] = 32'h8;
        @(negedge clk);
        tests_run++; if (bus.p_rdata_o !== 32'h1122_33EE) begin tests_failed++; $display("FAIL wr_readback_8: got %h want 112233ee", bus.p_rdata_o); end
        bus.p_addr_i[0] = 32'hC;
        @(negedge clk);
        tests_run++; if (bus.p_rdata_o !== 32'h0000_BBBB) begin tests_failed++; $display("FAIL wr_readback_c: got %h want 0000bbbb", bus.p_rdata_o); end
        clear_inputs();
    endtask

    task automatic test_reset_mid_single();
        @(negedge clk);
        bus.p_req_i = 2'b01; bus.p_addr_i[0] = 32'h10;
        #1;
        tests_run++; if (bus.p_gnt_o !== 2'b01) begin tests_failed++; $display("FAIL rst1_pre_gnt: got %b want 01", bus.p_gnt_o); end
        #1 rst_i = 1'b1;
        #1;
        tests_run++; if (bus.p_gnt_o !== 2'b00) begin tests_failed++; $display("FAIL rst1_gnt: got %b want 00", bus.p_gnt_o); end
        tests_run++; if (bus.ram_en_o !== 1'b0) begin tests_failed++; $display("FAIL rst1_en: got %b want 0", bus.ram_en_o); end
        @(negedge clk);
        rst_i = 1'b0;
        clear_inputs();
        @(negedge clk);
        tests_run++; if (bus.p_rvalid_o !== 2'b00) begin tests_failed++; $display("FAIL rst1_rvalid: got %b want 00", bus.p_rvalid_o); end
        bus.p_req_i = 2'b10; bus.p_addr_i[1] = 32'h4;
        #1;
        tests_run++; if (bus.p_gnt_o !== 2'b10) begin tests_failed++; $display("FAIL rst1_next_gnt: got %b want 10", bus.p_gnt_o); end
        @(negedge clk);
        tests_run++; if (bus.p_rdata_o !== 32'h1) begin tests_failed++; $display("FAIL rst1_next_rdata: got %h want 1", bus.p_rdata_o); end
        clear_inputs();
    endtask

`ifdef RAM_ARB_BURST_EN
    task automatic test_burst_read();
        logic [31:0] exp_a;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (k > 0) begin
                tests_run++; if (bus.p_rvalid_o !== 2'b10) begin tests_failed++; $display("FAIL bread_rvalid[%0d]: got %b want 10", k, bus.p_rvalid_o); end
                tests_run++; if (bus.p_rdata_o !== 32'(7 + k)) begin tests_failed++; $display("FAIL bread_rdata[%0d]: got %h want %h", k, bus.p_rdata_o, 32'(7 + k)); end
            end
            bus.p_req_i = (k == 0) ? 2'b10 : 2'b11;
            bus.p_burst_i = 2'b10;
            bus.p_addr_i[1] = 32'h22;
            bus.p_addr_i[0] = 32'h0;
            #1;
            exp_a = 32'h20 + 32'(4 * k);
            tests_run++; if (bus.p_gnt_o !== 2'b10) begin tests_failed++; $display("FAIL bread_gnt[%0d]: got %b want 10", k, bus.p_gnt_o); end
            tests_run++; if (bus.ram_addr_o !== exp_a) begin tests_failed++; $display("FAIL bread_addr[%0d]: got %h want %h", k, bus.ram_addr_o, exp_a); end
        end
        @(negedge clk);
        tests_run++; if (bus.p_rdata_o !== 32'd11) begin tests_failed++; $display("FAIL bread_rdata_last: got %h want b", bus.p_rdata_o); end
        bus.p_req_i = 2'b01; bus.p_burst_i = 2'b00;
        #1;
        tests_run++; if (bus.p_gnt_o !== 2'b01) begin tests_failed++; $display("FAIL bread_after_gnt: got %b want 01", bus.p_gnt_o); end
        @(negedge clk);
        clear_inputs();
    endtask

    task automatic test_burst_write_abort();
        load_mem();
        @(negedge clk);
        bus.p_req_i = 2'b01; bus.p_burst_i = 2'b01; bus.p_we_i[0] = WE_WORD; bus.p_addr_i[0] = 32'h0; bus.p_wdata_i[0] = 32'hA;
        #1;
        tests_run++; if (bus.ram_addr_o !== 32'h0) begin tests_failed++; $display("FAIL bwr_addr0: got %h want 0", bus.ram_addr_o); end
        @(negedge clk);
        bus.p_wdata_i[0] = 32'hB;
        #1;
        tests_run++; if (bus.ram_addr_o !== 32'h4) begin tests_failed++; $display("FAIL bwr_addr1: got %h want 4", bus.ram_addr_o); end
        tests_run++; if (bus.ram_din_o !== 32'hB) begin tests_failed++; $display("FAIL bwr_din1: got %h want b", bus.ram_din_o); end
        @(negedge clk);
        bus.p_req_i = 2'b00;
        #1;
        tests_run++; if (bus.ram_en_o !== 1'b0) begin tests_failed++; $display("FAIL bwr_abort_en: got %b want 0", bus.ram_en_o); end
        tests_run++; if (bus.ram_we_o !== 4'b0000) begin tests_failed++; $display("FAIL bwr_abort_we: got %b want 0000", bus.ram_we_o); end
        @(negedge clk);
        clear_inputs();
        bus.p_req_i = 2'b10; bus.p_addr_i[1] = 32'h0;
        #1;
        tests_run++; if (bus.p_gnt_o !== 2'b10) begin tests_failed++; $display("FAIL bwr_idle_gnt: got %b want 10", bus.p_gnt_o); end
        @(negedge clk);
        tests_run++; if (bus.p_rdata_o !== 32'hA) begin tests_failed++; $display("FAIL bwr_rb0: got %h want a", bus.p_rdata_o); end
        bus.p_addr_i[1] = 32'h4;
        @(negedge clk);
        tests_run++; if (bus.p_rdata_o !== 32'hB) begin tests_failed++; $display("FAIL bwr_rb4: got %h want b", bus.p_rdata_o); end
        bus.p_addr_i[1] = 32'h8;
        @(negedge clk);
        tests_run++; if (bus.p_rdata_o !== 32'h2) begin tests_failed++; $display("FAIL bwr_rb8: got %h want 2", bus.p_rdata_o); end
        clear_inputs();
    endtask

    task automatic test_burst_wrap();
        logic [31:0] exp_a;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            bus.p_req_i = 2'b01; bus.p_burst_i = 2'b01; bus.p_addr_i[0] = 32'hFFFF_FFF8;
            #1;
            exp_a = 32'hFFFF_FFF8 + 32'(4 * k);
            tests_run++; if (bus.ram_addr_o !== exp_a) begin tests_failed++; $display("FAIL bwrap_addr[%0d]: got %h want %h", k, bus.ram_addr_o, exp_a); end
        end
        @(negedge clk);
        clear_inputs();
    endtask

    task automatic test_reset_mid_burst();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            bus.p_req_i = 2'b10; bus.p_burst_i = 2'b10; bus.p_addr_i[1] = 32'h40;
            #1;
            tests_run++; if (bus.ram_addr_o !== 32'h40 + 32'(4 * k)) begin tests_failed++; $display("FAIL brst_addr[%0d]: got %h want %h", k, bus.ram_addr_o, 32'h40 + 32'(4 * k)); end
        end
        #1 rst_i = 1'b1;
        #1;
        tests_run++; if (bus.p_gnt_o !== 2'b00) begin tests_failed++; $display("FAIL brst_gnt: got %b want 00", bus.p_gnt_o); end
        tests_run++; if (bus.p_rvalid_o !== 2'b00) begin tests_failed++; $display("FAIL brst_rvalid: got %b want 00", bus.p_rvalid_o); end
        tests_run++; if (bus.p_rdata_o !== 32'h0) begin tests_failed++; $display("FAIL brst_rdata: got %h want 0", bus.p_rdata_o); end
        @(negedge clk);
        rst_i = 1'b0;
        clear_inputs();
        @(negedge clk);
        tests_run++; if (bus.p_rvalid_o !== 2'b00) begin tests_failed++; $display("FAIL brst_release_rvalid: got %b want 00", bus.p_rvalid_o); end
        bus.p_req_i = 2'b01; bus.p_addr_i[0] = 32'h10;
        #1;
        tests_run++; if (bus.p_gnt_o !== 2'b01) begin tests_failed++; $display("FAIL brst_next_gnt: got %b want 01", bus.p_gnt_o); end
        @(negedge clk);
        tests_run++; if (bus.p_rdata_o !== 32'h4) begin tests_failed++; $display("FAIL brst_next_rdata: got %h want 4", bus.p_rdata_o); end
        clear_inputs();
    endtask
`else
    task automatic test_burst_ignored();
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            if (k > 0) begin
                tests_run++; if (bus.p_rdata_o !== 32'h8) begin tests_failed++; $display("FAIL nob_rdata[%0d]: got %h want 8", k, bus.p_rdata_o); end
            end
            bus.p_req_i = 2'b10; bus.p_burst_i = 2'b11; bus.p_addr_i[1] = 32'h22;
            #1;
            tests_run++; if (bus.p_gnt_o !== 2'b10) begin tests_failed++; $display("FAIL nob_gnt[%0d]: got %b want 10", k, bus.p_gnt_o); end
            tests_run++; if (bus.ram_addr_o !== 32'h22) begin tests_failed++; $display("FAIL nob_addr[%0d]: got %h want 22", k, bus.ram_addr_o); end
        end
        @(negedge clk);
        tests_run++; if (bus.p_rvalid_o !== 2'b10) begin tests_failed++; $display("FAIL nob_rvalid: got %b want 10", bus.p_rvalid_o); end
        bus.p_req_i = 2'b00;
        #1;
        tests_run++; if (bus.p_gnt_o !== 2'b00) begin tests_failed++; $display("FAIL nob_no_extra_gnt: got %b want 00", bus.p_gnt_o); end
        bus.p_req_i = 2'b01; bus.p_addr_i[0] = 32'h4;
        #1;
        tests_run++; if (bus.p_gnt_o !== 2'b01) begin tests_failed++; $display("FAIL nob_other_port_gnt: got %b want 01", bus.p_gnt_o); end
        @(negedge clk);
        clear_inputs();
    endtask
`endif

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        mem_load     = 1'b0;
        rst_i        = 1'b0;
        clear_inputs();
        #1 rst_i = 1'b1;
        load_mem();
        test_reset();
        test_rr_after_reset();
        test_back_to_back();
        test_single_read();
        test_write_strobes();
        test_reset_mid_single();
`ifdef RAM_ARB_BURST_EN
        test_burst_read();
        test_burst_write_abort();
        test_burst_wrap();
        test_reset_mid_burst();
`else
        test_burst_ignored();
`endif
        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
